// File: rtl/ahb_spi_bridge_slave.sv
// AHB-Lite slave with a four-register map driving an 8-bit SPI mode-0 master.
// A TXDATA write launches one frame; the received byte is read back via RXDATA.
module ahb_spi_bridge_slave #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [7:0]  DIV_RESET  = 8'd3
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [31:0]           HRDATA,
    output logic                  HRESP,
    output logic                  SCLK,
    output logic                  MOSI,
    input  logic                  MISO,
    output logic                  SS_n
);

    typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_HOLD} state_t;

    // Bus handshake: an access is captured when HSEL & HREADY & HTRANS[1] and
    // executes in the next cycle; it completes on the first edge with HREADYOUT=1.
    logic       r_dp_valid;
    logic       r_dp_write;
    logic [5:0] r_dp_addr;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_clkdiv;
    logic [7:0] r_div_q;
    logic [7:0] r_half_cnt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift_tx;
    logic [7:0] r_shift_rx;
    logic [7:0] r_rx_byte;
    logic       r_rx_valid;
    logic       r_sclk;
    logic       r_mosi;
    logic       r_ss_n;

    logic w_wr, w_rd, w_tx_wr, w_ctrl_wr, w_rx_rd, w_busy, w_start, w_half_done;
    logic w_unused;

    assign w_unused = ^{HSIZE, HWDATA[31:8], HADDR};

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_addr  <= '0;
        end else if (HREADY) begin
            r_dp_valid <= HSEL & HTRANS[1];
            r_dp_write <= HWRITE;
            r_dp_addr  <= HADDR[7:2];
        end
    end

    assign w_wr        = r_dp_valid & r_dp_write;
    assign w_rd        = r_dp_valid & ~r_dp_write;
    assign w_tx_wr     = w_wr && (r_dp_addr == 6'd0);
    assign w_ctrl_wr   = w_wr && (r_dp_addr == 6'd3);
    assign w_rx_rd     = w_rd && (r_dp_addr == 6'd1);
    assign w_busy      = (r_state != ST_IDLE);
    assign w_start     = w_tx_wr && !w_busy;
    assign w_half_done = (r_half_cnt == r_div_q);

    // A TXDATA write arriving mid-frame is held off until the shifter is free.
    assign HREADYOUT = !(w_tx_wr && w_busy);
    assign HRESP     = 1'b0;
    assign SCLK      = r_sclk;
    assign MOSI      = r_mosi;
    assign SS_n      = r_ss_n;

    always_comb begin
        HRDATA = 32'h0;
        if (w_rd) begin
            case (r_dp_addr)
                6'd1:    HRDATA = {24'h0, r_rx_byte};
                6'd2:    HRDATA = {30'h0, r_rx_valid, w_busy};
                6'd3:    HRDATA = {24'h0, r_clkdiv};
                default: HRDATA = 32'h0;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_nxt = ST_XFER;
            ST_XFER: if (w_half_done && r_sclk && (r_bit_cnt == 3'd7)) w_state_nxt = ST_HOLD;
            ST_HOLD: if (w_half_done) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_clkdiv   <= DIV_RESET;
            r_div_q    <= '0;
            r_half_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift_tx <= '0;
            r_shift_rx <= '0;
            r_rx_byte  <= '0;
            r_rx_valid <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_ss_n     <= 1'b1;
        end else begin
            if (w_ctrl_wr) r_clkdiv <= HWDATA[7:0];
            // Completion below is written later so it overrides this clear.
            if (w_rx_rd) r_rx_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_div_q    <= r_clkdiv;
                        r_shift_tx <= HWDATA[7:0];
                        r_shift_rx <= '0;
                        r_ss_n     <= 1'b0;
                        r_mosi     <= HWDATA[7];
                        r_bit_cnt  <= '0;
                        r_half_cnt <= '0;
                    end
                end
                ST_XFER: begin
                    if (w_half_done) begin
                        r_half_cnt <= '0;
                        r_sclk     <= ~r_sclk;
                        if (!r_sclk) begin
                            r_shift_rx <= {r_shift_rx[6:0], MISO};
                        end else begin
                            r_shift_tx <= {r_shift_tx[6:0], 1'b0};
                            r_mosi     <= r_shift_tx[6];
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_half_cnt <= r_half_cnt + 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (w_half_done) begin
                        r_half_cnt <= '0;
                        r_ss_n     <= 1'b1;
                        r_mosi     <= 1'b0;
                        r_rx_byte  <= r_shift_rx;
                        r_rx_valid <= 1'b1;
                    end else begin
                        r_half_cnt <= r_half_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ahb_spi_bridge_slave.md
Name: ahb_spi_bridge_slave

Overview:
AHB-Lite slave that sits directly downstream of the AHB master and terminates its 8-bit-address bus. It exposes a four-register map and drives an 8-bit, SPI mode-0 master port toward an off-chip or on-chip SPI peripheral. A write to TXDATA starts one SPI frame, and the received byte is read back through RXDATA. This is the bus-to-SPI half of the SoC bridge.

Parameters:
ADDR_WIDTH, 8, width of HADDR.
DIV_RESET, 3, reset value of CTRL.CLKDIV; SCLK half-period = CLKDIV+1 HCLK cycles.

Ports:
HCLK  in  1  bus clock; all logic is on its rising edge.
HRESET  in  1  synchronous, active-high reset.
HSEL  in  1  slave select.
HADDR  in  ADDR_WIDTH  byte address.
HTRANS  in  2  transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
HWRITE  in  1  1=write, 0=read.
HSIZE  in  3  ignored; all accesses are treated as 32-bit.
HWDATA  in  32  write data (data phase).
HREADY  in  1  bus-level ready; gates address-phase capture.
HREADYOUT  out  1  slave ready; low = wait state.
HRDATA  out  32  read data (data phase).
HRESP  out  1  always 0 (OKAY).
SCLK  out  1  SPI clock, idle low.
MOSI  out  1  SPI data out, MSB first.
MISO  in  1  SPI data in.
SS_n  out  1  SPI slave select, active low.

Behaviour:
- Address-phase capture: when HSEL & HREADY & HTRANS[1], register HADDR[7:2], HWRITE and a valid flag. The access executes in the following (data-phase) cycle. BUSY/IDLE transfers and HSEL=0 capture valid=0.
- Register map (word offsets):
  - 0x00 TXDATA (W): HWDATA[7:0] is loaded into the shifter.
  - 0x04 RXDATA (R): {24'h0, rx_byte}. Reading it clears rx_valid.
  - 0x08 STATUS (R): {30'h0, rx_valid, busy}.
  - 0x0C CTRL (R/W): [7:0] CLKDIV.
  - Unmapped reads return 0; unmapped writes and writes to read-only registers are ignored.
- HRDATA: combinational from the latched data-phase address; 0 when not a valid read.
- HREADYOUT:
  - 1 except during the data phase of a TXDATA write while busy. It then stays low until the FSM returns to IDLE.
  - The write is accepted in the first cycle HREADYOUT=1.
  - Reads and all other writes take zero wait states.
- Reset values: HREADYOUT=1, HRDATA=0, HRESP=0, SCLK=0, MOSI=0, SS_n=1, CTRL.CLKDIV=DIV_RESET, rx_byte=0, rx_valid=0, FSM=IDLE.
- FSM IDLE -> XFER:
  - Trigger: accepted TXDATA write.
  - Same edge: latch CLKDIV into div_q, load shift_tx=HWDATA[7:0], SS_n<=0, MOSI<=bit7, bit_cnt=0, half-counter=0.
  - busy=1 from the next cycle.
- XFER: a half-period elapses when the half-counter reaches div_q (counter then resets).
  - Rising half (SCLK 0->1): sample MISO into shift_rx LSB.
  - Falling half (SCLK 1->0): shift; MOSI<=next bit; bit_cnt++.
  - After the 8th falling edge -> HOLD.
- HOLD: SCLK=0 for one half-period, then SS_n<=1, rx_byte<=shift_rx, rx_valid<=1, FSM -> IDLE, busy=0.
- Frame length: SS_n low for exactly 17*(div_q+1) cycles.
- CTRL write while busy: applies to the next frame only.
- RXDATA read in the same cycle that rx_valid is being set: the set wins (rx_valid=1 afterwards) and HRDATA returns the old rx_byte.
- STATUS read in the cycle before completion returns busy=1.
- HRESET mid-frame: the next edge forces reset values (SS_n=1, SCLK=0). The partial byte is discarded and rx_valid=0.
- Back-to-back TXDATA writes: the second stalls and starts a new frame in the same cycle the first returns to IDLE. SS_n is high for at least 1 cycle between frames.

Test Plan:
1. Reset, read CTRL/STATUS/RXDATA -> 0x03, 0x0, 0x0. HREADYOUT=1, SS_n=1, SCLK=0.
2. CLKDIV=3; write TXDATA=0xA5 with MISO looped to MOSI:
   - MOSI bit sequence 1,0,1,0,0,1,0,1.
   - 8 SCLK pulses, each 4 cycles high / 4 cycles low.
   - SS_n low for 68 cycles.
   - Then STATUS=0x2 and RXDATA=0xA5; STATUS then reads 0x0.
3. MISO tied 1, write TXDATA=0x00 -> RXDATA=0xFF. Write CTRL=0x00 -> frame lasts 17 cycles with SCLK toggling every cycle.
4. Write TXDATA=0x11 then immediately TXDATA=0x22 -> second data phase has HREADYOUT=0 until the first frame ends, then the 0x22 frame starts. Reads to STATUS during the stall are not issued, since the bus is held.
5. Assert HRESET at bit 4 of a frame -> next cycle SS_n=1, SCLK=0, STATUS=0. A subsequent 0x3C frame completes correctly.
6. Read address 0x10 -> HRDATA=0, HRESP=0. Write 0x10 and 0x04 -> no register changes. HTRANS=BUSY with HSEL=1 -> no access.
